// File: rtl/eth_pkg.sv
// eth_pkg: shared state encoding, CRC-32 constants and lane symbol helpers for the RMII/MII receive path.
package eth_pkg;
    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} rx_state_t;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;

    function automatic logic [3:0] pre_sym(input int lane_w);
        return (lane_w == 2) ? 4'h1 : 4'h5;
    endfunction

    function automatic logic [3:0] sfd_sym(input int lane_w);
        return (lane_w == 2) ? 4'h3 : 4'hD;
    endfunction
endpackage

// File: rtl/eth_crc32_byte.sv
// eth_crc32_byte: combinational byte-wide update of a reflected CRC-32 register.
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);
    always_comb begin
        crc_o = crc_i ^ {24'd0, data_i};
        for (int i = 0; i < 8; i++)
            crc_o = crc_o[0] ? ((crc_o >> 1) ^ CRC32_POLY_REFL) : (crc_o >> 1);
    end
endmodule

// File: rtl/eth_rx_mac_lane.sv
// eth_rx_mac_lane: RMII/MII receive front end; finds preamble/SFD, assembles LSB-first bytes,
// checks FCS, length, alignment and rx_er, and keeps saturating good/bad frame counters.
module eth_rx_mac_lane
    import eth_pkg::*;
#(
    parameter int LANE_W      = 2,
    parameter int MIN_PRE_SYM = 4,
    parameter int MIN_LEN     = 64,
    parameter int MAX_LEN     = 1522,
    parameter int CNT_W       = 16
) (
    input  logic              clk_50_mhz,
    input  logic              rst_n,
    input  logic              crs_dv,
    input  logic [LANE_W-1:0] rx_d,
    input  logic              rx_er,
    output logic [7:0]        m_data,
    output logic              m_valid,
    output logic              m_sof,
    output logic              m_eof,
    output logic              m_err,
    output logic [15:0]       frame_len,
    output logic [CNT_W-1:0]  frames_ok,
    output logic [CNT_W-1:0]  frames_bad
);
    localparam int                SPB      = 8 / LANE_W;
    localparam logic [1:0]        SYM_LAST = 2'(SPB - 1);
    localparam logic [LANE_W-1:0] PRE_S    = LANE_W'(pre_sym(LANE_W));
    localparam logic [LANE_W-1:0] SFD_S    = LANE_W'(sfd_sym(LANE_W));
    localparam logic [7:0]        PRE_MIN  = 8'(MIN_PRE_SYM);
    localparam logic [15:0]       LEN_MIN  = 16'(MIN_LEN);
    localparam logic [15:0]       LEN_MAX  = 16'(MAX_LEN);

    if (LANE_W != 2 && LANE_W != 4) begin : g_bad_lane
        $error("eth_rx_mac_lane: LANE_W must be 2 or 4, got %0d", LANE_W);
    end

    rx_state_t         state_q;
    logic              crs_q, rxer_q;
    logic [LANE_W-1:0] rxd_q;
    logic [7:0]        byte_q, byte_d, pre_cnt_q;
    logic [1:0]        sym_cnt_q;
    logic [15:0]       len_q;
    logic [31:0]       crc_q, crc_d;
    logic              err_rx_q, err_long_q, in_frame_q;
    logic              is_pre, is_sfd, sym_last, end_d, fail_d;
    logic [7:0]        m_data_q;
    logic              m_valid_q, m_sof_q, m_eof_q, m_err_q;
    logic [15:0]       frame_len_q;
    logic [CNT_W-1:0]  frames_ok_q, frames_bad_q;

    eth_crc32_byte u_crc (.crc_i(crc_q), .data_i(byte_d), .crc_o(crc_d));

    // Symbols arrive LSB-first, so each new symbol enters at the top of the byte.
    always_comb begin
        byte_d   = {rxd_q, byte_q[7:LANE_W]};
        is_pre   = rxd_q == PRE_S;
        is_sfd   = rxd_q == SFD_S;
        sym_last = sym_cnt_q == SYM_LAST;
        end_d    = !crs_q && (state_q == DATA || (state_q == DROP && in_frame_q));
        fail_d   = err_rx_q | err_long_q | (len_q < LEN_MIN) | (crc_q != CRC32_RESIDUE)
                 | (state_q == DATA && sym_cnt_q != 2'd0);
    end

    always_ff @(posedge clk_50_mhz or negedge rst_n) begin
        if (!rst_n) begin
            crs_q        <= 1'b0;
            rxer_q       <= 1'b0;
            rxd_q        <= '0;
            state_q      <= IDLE;
            byte_q       <= 8'd0;
            pre_cnt_q    <= 8'd0;
            sym_cnt_q    <= 2'd0;
            len_q        <= 16'd0;
            crc_q        <= CRC32_INIT;
            err_rx_q     <= 1'b0;
            err_long_q   <= 1'b0;
            in_frame_q   <= 1'b0;
            m_data_q     <= 8'd0;
            m_valid_q    <= 1'b0;
            m_sof_q      <= 1'b0;
            m_eof_q      <= 1'b0;
            m_err_q      <= 1'b0;
            frame_len_q  <= 16'd0;
            frames_ok_q  <= '0;
            frames_bad_q <= '0;
        end else begin
            crs_q     <= crs_dv;
            rxd_q     <= rx_d;
            rxer_q    <= rx_er;
            m_valid_q <= 1'b0;
            m_sof_q   <= 1'b0;
            m_eof_q   <= 1'b0;
            m_err_q   <= 1'b0;
            case (state_q)
                IDLE: if (crs_q) begin
                    if (is_pre) begin
                        state_q   <= PRE;
                        pre_cnt_q <= 8'd1;
                        crc_q     <= CRC32_INIT;
                    end else begin
                        state_q    <= DROP;
                        in_frame_q <= 1'b0;
                    end
                end
                PRE: begin
                    if (crs_q && is_pre) begin
                        if (~&pre_cnt_q) pre_cnt_q <= pre_cnt_q + 8'd1;
                    end else if (crs_q && is_sfd && pre_cnt_q >= PRE_MIN) begin
                        state_q    <= DATA;
                        len_q      <= 16'd0;
                        sym_cnt_q  <= 2'd0;
                        err_rx_q   <= 1'b0;
                        err_long_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DATA: if (!crs_q) begin
                    state_q <= IDLE;
                end else begin
                    byte_q    <= byte_d;
                    err_rx_q  <= err_rx_q | rxer_q;
                    sym_cnt_q <= sym_last ? 2'd0 : sym_cnt_q + 2'd1;
                    if (sym_last) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= byte_d;
                        m_sof_q   <= len_q == 16'd0;
                        crc_q     <= crc_d;
                        len_q     <= len_q + 16'd1;
                        if (len_q + 16'd1 == LEN_MAX) begin
                            err_long_q <= 1'b1;
                            in_frame_q <= 1'b1;
                            state_q    <= DROP;
                        end
                    end
                end
                DROP: if (!crs_q) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (end_d) begin
                m_eof_q     <= 1'b1;
                m_err_q     <= fail_d;
                frame_len_q <= len_q;
                if (fail_d && ~&frames_bad_q) frames_bad_q <= frames_bad_q + 1'b1;
                if (!fail_d && ~&frames_ok_q) frames_ok_q <= frames_ok_q + 1'b1;
            end
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_sof      = m_sof_q;
    assign m_eof      = m_eof_q;
    assign m_err      = m_err_q;
    assign frame_len  = frame_len_q;
    assign frames_ok  = frames_ok_q;
    assign frames_bad = frames_bad_q;
endmodule
